// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the 3x3 window front end of the CNN pipeline.
package cnn_pkg;

    // Default pixel width and image geometry
    localparam int unsigned W_DEF  = 32;
    localparam int unsigned IW_DEF = 28;
    localparam int unsigned IH_DEF = 28;

    // Window geometry; window slot (r, c) lives at index WIN_COLS*r + c
    localparam int unsigned WIN_ROWS = 3;
    localparam int unsigned WIN_COLS = 3;
    localparam int unsigned WIN_N    = WIN_ROWS * WIN_COLS;
    localparam int unsigned WIN_TOP  = 0;
    localparam int unsigned WIN_MID  = 1;
    localparam int unsigned WIN_BOT  = 2;

    // Bits needed to count 0..n-1 (never less than 1)
    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_win3x3_if.sv
// Window output handshake: valid/ready with data and end-of-frame marker.
interface conv_win3x3_if
    import cnn_pkg::*;
#(
    parameter int unsigned W = W_DEF
) ();

    logic               win_valid;
    logic               win_ready;
    logic [9*W-1:0]     win_data;
    logic               win_last;

    modport master (
        output win_valid,
        output win_data,
        output win_last,
        input  win_ready
    );

    modport slave (
        input  win_valid,
        input  win_data,
        input  win_last,
        output win_ready
    );

endinterface

// File: rtl/win_linebuf.sv
// Two chained IW-deep line buffers; one write per consumed pixel, contents never reset.
module win_linebuf
    import cnn_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned IW = IW_DEF
) (
    input  logic         clk_i,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] row1_o,   // pixel one row above the incoming one
    output logic [W-1:0] row2_o    // pixel two rows above the incoming one
);

    logic [W-1:0] line1_q [IW];
    logic [W-1:0] line1_d [IW];
    logic [W-1:0] line2_q [IW];
    logic [W-1:0] line2_d [IW];

    // Shift both lines by one pixel on each enabled cycle; line 2 is fed from line 1's tail
    always_comb begin
        line1_d = line1_q;
        line2_d = line2_q;
        if (en_i) begin
            line1_d[0] = din_i;
            line2_d[0] = line1_q[IW-1];
            for (int i = 1; i < IW; i++) begin
                line1_d[i] = line1_q[i-1];
                line2_d[i] = line2_q[i-1];
            end
        end
    end

    // Line storage
    always_ff @(posedge clk_i) begin
        line1_q <= line1_d;
        line2_q <= line2_d;
    end

    assign row1_o = line1_q[IW-1];
    assign row2_o = line2_q[IW-1];

endmodule

// File: rtl/conv_win3x3.sv
// 3x3 sliding-window generator fed by a 1-cycle-latency FIFO, with a 2-entry input skid.
module conv_win3x3
    import cnn_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned IW = IW_DEF,
    parameter int unsigned IH = IH_DEF
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          rclr,
    input  logic [W-1:0]  din,
    input  logic          rempty,
    output logic          re,
    conv_win3x3_if.master win,
    output logic          frame_done
);

    localparam int unsigned CW = clog2w(IW);
    localparam int unsigned RW = clog2w(IH);

    logic          clr;
    logic          push;
    logic          consume;
    logic [W-1:0]  pix;
    logic [W-1:0]  lb_row1;
    logic [W-1:0]  lb_row2;

    logic [1:0]    skid_cnt_q, skid_cnt_d;
    logic [W-1:0]  skid_q [2];
    logic [W-1:0]  skid_d [2];
    logic          inflight_q, inflight_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [W-1:0]  win_q [WIN_N];
    logic [W-1:0]  win_d [WIN_N];
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;
    logic          frame_done_q, frame_done_d;

    assign clr = rrst | rclr;

    // Never issue a read that the skid could not absorb; a read during clear would be discarded
    assign re = !clr && !rempty && ((skid_cnt_q + {1'b0, inflight_q}) < 2'd2);

    // Next-state for skid, counters, window and output handshake
    always_comb begin
        push         = inflight_q;
        consume      = (skid_cnt_q != 2'd0) && (!win_valid_q || win.win_ready);
        pix          = skid_q[0];
        skid_d       = skid_q;
        skid_cnt_d   = skid_cnt_q + {1'b0, push} - {1'b0, consume};
        inflight_d   = re;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_last_d   = win_last_q;
        frame_done_d = win_valid_q && win.win_ready && win_last_q;

        case ({push, consume})
            2'b10: skid_d[skid_cnt_q[0]] = din;
            2'b01: skid_d[0] = skid_q[1];
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_d[0] = din;
                end else begin
                    skid_d[0] = skid_q[1];
                    skid_d[1] = din;
                end
            end
            default: ;
        endcase

        if (consume) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r+1];
                win_d[3*r + 1] = win_q[3*r+2];
            end
            win_d[WIN_COLS*WIN_TOP + 2] = lb_row2;
            win_d[WIN_COLS*WIN_MID + 2] = lb_row1;
            win_d[WIN_COLS*WIN_BOT + 2] = pix;

            if (col_q == CW'(IW - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IH - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            // Window columns are all from the current frame once col >= 2 and row >= 2
            win_valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
            win_last_d  = win_valid_d && (row_q == RW'(IH - 1)) && (col_q == CW'(IW - 1));
        end else if (win_valid_q && win.win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    // Control and window state, cleared by reset or frame abort
    always_ff @(posedge rclk) begin
        if (clr) begin
            skid_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
        end else begin
            skid_cnt_q   <= skid_cnt_d;
            inflight_q   <= inflight_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Skid payload; only meaningful below skid_cnt_q
    always_ff @(posedge rclk) begin
        skid_q <= skid_d;
    end

    win_linebuf #(
        .W  (W),
        .IW (IW)
    ) u_linebuf (
        .clk_i  (rclk),
        .en_i   (consume && !clr),
        .din_i  (pix),
        .row1_o (lb_row1),
        .row2_o (lb_row2)
    );

    // Flatten the window registers onto the output bus
    always_comb begin
        win.win_data = '0;
        for (int i = 0; i < WIN_N; i++) begin
            win.win_data[i*W +: W] = win_q[i];
        end
    end

    assign win.win_valid = win_valid_q;
    assign win.win_last  = win_last_q;
    assign frame_done    = frame_done_q;

endmodule
